// File: rtl/fill_pkg.sv
// fill_pkg: shared state codes, error/beeper codes and BCD helpers for the pill fill sequencer
//   state_t      : SETTING=0 RUNNING=1 SWITCHING=2 DONE=3 ERROR=4 FATAL=5
//   ERR_*        : err_code values
//   BEEP_*       : beep_mode values
//   bcd_inc      : three-digit BCD increment
//   targets_valid: all digits 0-9 and both targets nonzero
package fill_pkg;

   typedef enum logic [2:0] {
      S_SETTING   = 3'd0,
      S_RUNNING   = 3'd1,
      S_SWITCHING = 3'd2,
      S_DONE      = 3'd3,
      S_ERROR     = 3'd4,
      S_FATAL     = 3'd5
   } state_t;

   localparam logic [1:0] ERR_NONE     = 2'd0;
   localparam logic [1:0] ERR_HOPPER   = 2'd1;
   localparam logic [1:0] ERR_CONVEYOR = 2'd2;
   localparam logic [1:0] ERR_ESTOP    = 2'd3;

   localparam logic [1:0] BEEP_OFF  = 2'd0;
   localparam logic [1:0] BEEP_CONT = 2'd1;
   localparam logic [1:0] BEEP_2HZ  = 2'd2;
   localparam logic [1:0] BEEP_4HZ  = 2'd3;

   function automatic logic [11:0] bcd_inc(input logic [11:0] v);
      logic [11:0] r;
      logic c;
      r = v;
      c = 1'b1;
      for (int i = 0; i < 3; i++) begin
         if (c) begin
            if (r[4*i +: 4] == 4'd9) r[4*i +: 4] = 4'd0;
            else begin
               r[4*i +: 4] = r[4*i +: 4] + 4'd1;
               c = 1'b0;
            end
         end
      end
      return r;
   endfunction

   function automatic logic targets_valid(input logic [11:0] p, input logic [7:0] b);
      return p[11:8] <= 4'd9 && p[7:4] <= 4'd9 && p[3:0] <= 4'd9 &&
             b[7:4] <= 4'd9 && b[3:0] <= 4'd9 && p != 12'h000 && b != 8'h00;
   endfunction

endpackage

// File: rtl/fill_sequencer_tick_timer.sv
// tick_timer: loadable down-counter; expired pulses on the enabled tick that takes it from 1 to 0
//   clk_1khz, switch_clr : clock, async active-high reset (count cleared)
//   load, load_val       : load has priority over counting
//   en                   : count down while high (stops at 0)
//   expired              : high during the last enabled tick
module tick_timer #(
   parameter int WIDTH = 8
) (
   input  logic             clk_1khz,
   input  logic             switch_clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   output logic             expired
);

   logic [WIDTH-1:0] count;

   always_ff @(posedge clk_1khz or posedge switch_clr)
      if (switch_clr) count <= '0;
      else if (load) count <= load_val;
      else if (en && count != '0) count <= count - 1'b1;

   assign expired = en && (count == WIDTH'(1));

endmodule

// File: rtl/fill_sequencer.sv
// fill_sequencer: pill-bottling sequencer (fill, bottle change, fault handling) on a 1 kHz clock
//   inputs : clk_1khz, switch_clr (async reset), start, clr_err, estop, pill_pulse,
//            conveyor_ok, target_pills (3-digit BCD), target_bottles (2-digit BCD)
//   outputs: state, now_pills, now_bottles (BCD), hopper_en, conveyor_en, err_code, beep_mode
module fill_sequencer
   import fill_pkg::*;
#(
   parameter int TICKS_PER_SEC = 1000,
   parameter int SWITCH_SEC    = 2,
   parameter int HOPPER_SEC    = 3
) (
   input  logic        clk_1khz,
   input  logic        switch_clr,
   input  logic        start,
   input  logic        clr_err,
   input  logic        estop,
   input  logic        pill_pulse,
   input  logic        conveyor_ok,
   input  logic [11:0] target_pills,
   input  logic [7:0]  target_bottles,
   output logic [2:0]  state,
   output logic [11:0] now_pills,
   output logic [7:0]  now_bottles,
   output logic        hopper_en,
   output logic        conveyor_en,
   output logic [1:0]  err_code,
   output logic [1:0]  beep_mode
);

   localparam int HOP_TICKS = HOPPER_SEC * TICKS_PER_SEC;
   localparam int SW_TICKS  = SWITCH_SEC * TICKS_PER_SEC;
   localparam int TW        = $clog2((HOP_TICKS > SW_TICKS ? HOP_TICKS : SW_TICKS) + 1);

   state_t      st;
   logic [1:0]  estop_sync;
   logic [2:0]  pill_sync;
   logic [11:0] tgt_pills;
   logic [7:0]  tgt_bottles;
   logic [11:0] pills_inc, bottles_inc;
   logic        estop_s, pill, go, full, last;
   logic        hop_load, sw_load, hop_exp, sw_exp;

   always_ff @(posedge clk_1khz or posedge switch_clr)
      if (switch_clr) begin
         estop_sync <= '0;
         pill_sync  <= '0;
      end else begin
         estop_sync <= {estop_sync[0], estop};
         pill_sync  <= {pill_sync[1:0], pill_pulse};
      end

   assign estop_s     = estop_sync[1];
   assign pill        = pill_sync[1] & ~pill_sync[2];
   assign go          = start && targets_valid(target_pills, target_bottles);
   assign pills_inc   = bcd_inc(now_pills);
   assign bottles_inc = bcd_inc({4'h0, now_bottles});
   assign full        = now_pills == tgt_pills;
   assign last        = bottles_inc == {4'h0, tgt_bottles};
   assign state       = st;

   // A full bottle is closed before any further pill is counted, so a late pill cannot overfill.
   assign hop_load = !estop_s && ((st == S_SETTING && go) ||
                                  (st == S_RUNNING && !full && pill) ||
                                  (st == S_SWITCHING && sw_exp && conveyor_ok) ||
                                  (st == S_ERROR && clr_err && err_code == ERR_HOPPER));
   assign sw_load  = !estop_s && ((st == S_RUNNING && full && !last) ||
                                  (st == S_ERROR && clr_err && err_code == ERR_CONVEYOR));

   tick_timer #(.WIDTH(TW)) u_hopper (
      .clk_1khz(clk_1khz), .switch_clr(switch_clr), .load(hop_load),
      .load_val(TW'(HOP_TICKS)), .en(st == S_RUNNING), .expired(hop_exp)
   );

   tick_timer #(.WIDTH(TW)) u_switch (
      .clk_1khz(clk_1khz), .switch_clr(switch_clr), .load(sw_load),
      .load_val(TW'(SW_TICKS)), .en(st == S_SWITCHING), .expired(sw_exp)
   );

   always_ff @(posedge clk_1khz or posedge switch_clr)
      if (switch_clr) begin
         st          <= S_SETTING;
         now_pills   <= '0;
         now_bottles <= '0;
         tgt_pills   <= '0;
         tgt_bottles <= '0;
         hopper_en   <= 1'b0;
         conveyor_en <= 1'b0;
         err_code    <= ERR_NONE;
         beep_mode   <= BEEP_OFF;
      end else if (estop_s) begin
         st          <= S_FATAL;
         hopper_en   <= 1'b0;
         conveyor_en <= 1'b0;
         err_code    <= ERR_ESTOP;
         beep_mode   <= BEEP_CONT;
      end else begin
         case (st)
            S_SETTING:
               if (go) begin
                  st          <= S_RUNNING;
                  now_pills   <= '0;
                  now_bottles <= '0;
                  tgt_pills   <= target_pills;
                  tgt_bottles <= target_bottles;
                  hopper_en   <= 1'b1;
               end
            S_RUNNING:
               if (full) begin
                  now_bottles <= bottles_inc[7:0];
                  hopper_en   <= 1'b0;
                  st          <= last ? S_DONE : S_SWITCHING;
                  conveyor_en <= !last;
                  beep_mode   <= last ? BEEP_4HZ : BEEP_OFF;
               end else if (pill) now_pills <= pills_inc;
               else if (hop_exp) begin
                  st        <= S_ERROR;
                  hopper_en <= 1'b0;
                  err_code  <= ERR_HOPPER;
                  beep_mode <= BEEP_2HZ;
               end
            S_SWITCHING:
               if (sw_exp) begin
                  conveyor_en <= 1'b0;
                  if (conveyor_ok) begin
                     st        <= S_RUNNING;
                     now_pills <= '0;
                     hopper_en <= 1'b1;
                  end else begin
                     st        <= S_ERROR;
                     err_code  <= ERR_CONVEYOR;
                     beep_mode <= BEEP_2HZ;
                  end
               end
            S_DONE:
               if (start) begin
                  st          <= S_SETTING;
                  now_pills   <= '0;
                  now_bottles <= '0;
                  beep_mode   <= BEEP_OFF;
               end
            S_ERROR:
               // err_code remembers which state faulted, so it selects the resume target
               if (clr_err) begin
                  st          <= err_code == ERR_HOPPER ? S_RUNNING : S_SWITCHING;
                  hopper_en   <= err_code == ERR_HOPPER;
                  conveyor_en <= err_code != ERR_HOPPER;
                  err_code    <= ERR_NONE;
                  beep_mode   <= BEEP_OFF;
               end
            S_FATAL: ;
            default: begin
               st          <= S_SETTING;
               hopper_en   <= 1'b0;
               conveyor_en <= 1'b0;
               err_code    <= ERR_NONE;
               beep_mode   <= BEEP_OFF;
            end
         endcase
      end

endmodule

// File: tb/tb_fill_sequencer.sv
// tb_fill_sequencer: randomized self-checking bench for fill_sequencer against a counting model
module tb_fill_sequencer;

   localparam logic [2:0] SET = 3'd0, RUN = 3'd1, SWI = 3'd2, DON = 3'd3, ERR = 3'd4, FAT = 3'd5;

   logic        clk_1khz = 1'b0, switch_clr = 1'b1, start = 1'b0, clr_err = 1'b0;
   logic        estop = 1'b0, pill_pulse = 1'b0, conveyor_ok = 1'b1;
   logic [11:0] target_pills = '0;
   logic [7:0]  target_bottles = '0;
   logic [2:0]  state;
   logic [11:0] now_pills;
   logic [7:0]  now_bottles;
   logic        hopper_en, conveyor_en;
   logic [1:0]  err_code, beep_mode;
   int          n_tests = 0, n_fail = 0;

   always #5 clk_1khz = ~clk_1khz;

   fill_sequencer #(.TICKS_PER_SEC(10), .SWITCH_SEC(2), .HOPPER_SEC(3)) dut (
      .clk_1khz(clk_1khz), .switch_clr(switch_clr), .start(start), .clr_err(clr_err),
      .estop(estop), .pill_pulse(pill_pulse), .conveyor_ok(conveyor_ok),
      .target_pills(target_pills), .target_bottles(target_bottles), .state(state),
      .now_pills(now_pills), .now_bottles(now_bottles), .hopper_en(hopper_en),
      .conveyor_en(conveyor_en), .err_code(err_code), .beep_mode(beep_mode)
   );

   function automatic logic [11:0] to_bcd(input int n);
      return {4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
   endfunction

   task automatic tick(input int n);
      repeat (n) @(negedge clk_1khz);
   endtask

   task automatic pulse_start;
      start = 1'b1; tick(1); start = 1'b0;
   endtask

   task automatic pulse_clr;
      clr_err = 1'b1; tick(1); clr_err = 1'b0;
   endtask

   // pill counted two edges after first sampling; returns on the negedge after the count
   task automatic send_pill;
      pill_pulse = 1'b1; tick(2); pill_pulse = 1'b0; tick(1);
   endtask

   task automatic do_reset;
      switch_clr = 1'b1; tick(2); switch_clr = 1'b0; tick(1);
   endtask

   task automatic test_reset;
      tick(2);
      n_tests++; if (state !== SET) begin n_fail++; $display("FAIL reset_state got %0d want %0d", state, SET); end
      n_tests++; if ({now_pills, now_bottles} !== 20'h0) begin n_fail++; $display("FAIL reset_counts got %h want 0", {now_pills, now_bottles}); end
      n_tests++; if ({hopper_en, conveyor_en, err_code, beep_mode} !== 6'b0) begin n_fail++; $display("FAIL reset_outputs got %b want 0", {hopper_en, conveyor_en, err_code, beep_mode}); end
      switch_clr = 1'b0; tick(1);
   endtask

   task automatic test_invalid_start;
      logic [19:0] bad [4];
      bad = '{20'h000_01, 20'h0A1_01, 20'h010_00, 20'h123_1A};
      for (int i = 0; i < 4; i++) begin
         {target_pills, target_bottles} = bad[i];
         pulse_start; tick(2);
         n_tests++; if (state !== SET || hopper_en !== 1'b0) begin n_fail++; $display("FAIL invalid_start_%0d got state %0d hopper %b want %0d 0", i, state, hopper_en, SET); end
      end
   endtask

   task automatic run_fill(input int tp, input int tb);
      target_pills = to_bcd(tp); target_bottles = 8'(to_bcd(tb));
      conveyor_ok = 1'b1;
      pulse_start;
      n_tests++; if (state !== RUN || hopper_en !== 1'b1) begin n_fail++; $display("FAIL fill_start got state %0d hopper %b want %0d 1", state, hopper_en, RUN); end
      target_pills = 12'($urandom); target_bottles = 8'($urandom);
      for (int b = 1; b <= tb; b++) begin
         for (int k = 1; k <= tp; k++) begin
            tick($urandom_range(0, 6));
            send_pill;
            n_tests++; if (now_pills !== to_bcd(k)) begin n_fail++; $display("FAIL fill_pills got %h want %h", now_pills, to_bcd(k)); end
         end
         tick(1);
         n_tests++; if (now_bottles !== 8'(to_bcd(b))) begin n_fail++; $display("FAIL fill_bottles got %h want %h", now_bottles, 8'(to_bcd(b))); end
         if (b < tb) begin
            n_tests++; if (state !== SWI || {hopper_en, conveyor_en} !== 2'b01) begin n_fail++; $display("FAIL switch_enter got state %0d en %b want %0d 01", state, {hopper_en, conveyor_en}, SWI); end
            tick(19);
            n_tests++; if (state !== SWI) begin n_fail++; $display("FAIL switch_dwell got %0d want %0d", state, SWI); end
            tick(1);
            n_tests++; if (state !== RUN || now_pills !== 12'h0 || hopper_en !== 1'b1) begin n_fail++; $display("FAIL switch_exit got state %0d pills %h want %0d 000", state, now_pills, RUN); end
         end else begin
            n_tests++; if (state !== DON || beep_mode !== 2'd3 || {hopper_en, conveyor_en} !== 2'b00) begin n_fail++; $display("FAIL done got state %0d beep %0d en %b want %0d 3 00", state, beep_mode, {hopper_en, conveyor_en}, DON); end
         end
      end
      tick(3);
      pulse_start;
      n_tests++; if (state !== SET || {now_pills, now_bottles, beep_mode} !== 22'h0) begin n_fail++; $display("FAIL done_exit got state %0d counts %h beep %0d want %0d 0 0", state, {now_pills, now_bottles}, beep_mode, SET); end
   endtask

   task automatic test_hopper_timeout;
      target_pills = 12'h005; target_bottles = 8'h01;
      pulse_start; send_pill; send_pill;
      tick(29);
      n_tests++; if (state !== RUN) begin n_fail++; $display("FAIL hopper_pre_expiry got %0d want %0d", state, RUN); end
      tick(1);
      n_tests++; if (state !== ERR || err_code !== 2'd1 || hopper_en !== 1'b0 || beep_mode !== 2'd2) begin n_fail++; $display("FAIL hopper_error got state %0d err %0d hopper %b beep %0d want %0d 1 0 2", state, err_code, hopper_en, beep_mode, ERR); end
      send_pill;
      n_tests++; if (now_pills !== 12'h002) begin n_fail++; $display("FAIL hopper_pill_ignored got %h want 002", now_pills); end
      pulse_clr;
      n_tests++; if (state !== RUN || err_code !== 2'd0 || hopper_en !== 1'b1 || now_pills !== 12'h002) begin n_fail++; $display("FAIL hopper_clear got state %0d err %0d pills %h want %0d 0 002", state, err_code, now_pills, RUN); end
      // pill edge lands on the exact expiry tick: must count and reload, not fault
      tick(27);
      pill_pulse = 1'b1; tick(2); pill_pulse = 1'b0; tick(1);
      n_tests++; if (state !== RUN || now_pills !== 12'h003) begin n_fail++; $display("FAIL hopper_coincide got state %0d pills %h want %0d 003", state, now_pills, RUN); end
      send_pill; send_pill; tick(1);
      n_tests++; if (state !== DON || now_bottles !== 8'h01) begin n_fail++; $display("FAIL hopper_finish got state %0d bottles %h want %0d 01", state, now_bottles, DON); end
      pulse_start;
   endtask

   task automatic test_conveyor_fault;
      target_pills = 12'h002; target_bottles = 8'h03; conveyor_ok = 1'b0;
      pulse_start; send_pill; send_pill; tick(1);
      n_tests++; if (state !== SWI || now_bottles !== 8'h01) begin n_fail++; $display("FAIL conv_switch got state %0d bottles %h want %0d 01", state, now_bottles, SWI); end
      tick(19);
      n_tests++; if (state !== SWI) begin n_fail++; $display("FAIL conv_dwell got %0d want %0d", state, SWI); end
      tick(1);
      n_tests++; if (state !== ERR || err_code !== 2'd2 || conveyor_en !== 1'b0 || beep_mode !== 2'd2) begin n_fail++; $display("FAIL conv_error got state %0d err %0d conv %b beep %0d want %0d 2 0 2", state, err_code, conveyor_en, beep_mode, ERR); end
      conveyor_ok = 1'b1; pulse_start; tick(2);
      n_tests++; if (state !== ERR) begin n_fail++; $display("FAIL conv_start_ignored got %0d want %0d", state, ERR); end
      pulse_clr;
      n_tests++; if (state !== SWI || conveyor_en !== 1'b1 || err_code !== 2'd0) begin n_fail++; $display("FAIL conv_clear got state %0d conv %b err %0d want %0d 1 0", state, conveyor_en, err_code, SWI); end
      tick(19);
      n_tests++; if (state !== SWI) begin n_fail++; $display("FAIL conv_redwell got %0d want %0d", state, SWI); end
      tick(1);
      n_tests++; if (state !== RUN || now_pills !== 12'h0 || now_bottles !== 8'h01) begin n_fail++; $display("FAIL conv_resume got state %0d pills %h bottles %h want %0d 000 01", state, now_pills, now_bottles, RUN); end
      do_reset;
   endtask

   task automatic test_estop;
      target_pills = 12'h010; target_bottles = 8'h01;
      pulse_start; send_pill;
      estop = 1'b1; tick(3);
      n_tests++; if (state !== FAT || err_code !== 2'd3 || beep_mode !== 2'd1 || {hopper_en, conveyor_en} !== 2'b00) begin n_fail++; $display("FAIL estop got state %0d err %0d beep %0d en %b want %0d 3 1 00", state, err_code, beep_mode, {hopper_en, conveyor_en}, FAT); end
      estop = 1'b0; tick(3); pulse_start; pulse_clr; tick(3);
      n_tests++; if (state !== FAT) begin n_fail++; $display("FAIL estop_latched got %0d want %0d", state, FAT); end
      #2 switch_clr = 1'b1; #1;
      n_tests++; if ({state, now_pills, now_bottles, hopper_en, conveyor_en, err_code, beep_mode} !== 29'h0) begin n_fail++; $display("FAIL estop_clear got state %0d err %0d beep %0d pills %h want 0", state, err_code, beep_mode, now_pills); end
      @(negedge clk_1khz) switch_clr = 1'b0; tick(1);
   endtask

   task automatic test_reset_mid_run;
      target_pills = to_bcd($urandom_range(10, 50)); target_bottles = 8'h02;
      pulse_start; send_pill; send_pill; send_pill;
      #2 switch_clr = 1'b1; #1;
      n_tests++; if (state !== SET || now_pills !== 12'h0 || hopper_en !== 1'b0) begin n_fail++; $display("FAIL reset_mid_run got state %0d pills %h hopper %b want 0 000 0", state, now_pills, hopper_en); end
      @(negedge clk_1khz) switch_clr = 1'b0; tick(1);
      send_pill;
      n_tests++; if (state !== SET || now_pills !== 12'h0) begin n_fail++; $display("FAIL reset_pill_ignored got state %0d pills %h want 0 000", state, now_pills); end
   endtask

   initial begin
      test_reset;
      test_invalid_start;
      run_fill(3, 2);
      run_fill(12, 1);
      run_fill(105, 1);
      repeat (4) run_fill($urandom_range(1, 20), $urandom_range(1, 3));
      test_hopper_timeout;
      test_conveyor_fault;
      test_estop;
      test_reset_mid_run;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fill_sequencer.md
FILL_SEQUENCER -- requirements
Module: fill_sequencer

Interface
REQ-001 Parameter TICKS_PER_SEC, default 1000, clk_1khz cycles per second.
REQ-002 Parameter SWITCH_SEC, default 2, bottle-change dwell in seconds.
REQ-003 Parameter HOPPER_SEC, default 3, maximum seconds allowed between pills before a starvation error.
REQ-004 Clock and reset SHALL be one clock, clk_1khz; reset switch_clr is asynchronous and active-high.
REQ-005 clk_1khz  in  1  system clock.
REQ-006 switch_clr  in  1  asynchronous active-high reset.
REQ-007 start  in  1  single-cycle pulse (QD), pre-debounced.
REQ-008 clr_err  in  1  single-cycle pulse, acknowledges ERROR.
REQ-009 estop  in  1  emergency-stop level, asynchronous to the clock.
REQ-010 pill_pulse  in  1  hopper pill signal, asynchronous; one pill per rising edge.
REQ-011 conveyor_ok  in  1  conveyor running level.
REQ-012 target_pills  in  12  BCD, 3 digits, 001-999.
REQ-013 target_bottles  in  8  BCD, 2 digits, 01-99.
REQ-014 state  out  3  current state code.
REQ-015 now_pills  out  12  BCD pill count in the current bottle.
REQ-016 now_bottles  out  8  BCD count of completed bottles.
REQ-017 hopper_en  out  1  hopper feed enable.
REQ-018 conveyor_en  out  1  conveyor drive enable.
REQ-019 err_code  out  2  error code: 0 none, 1 HOPPER, 2 CONVEYOR, 3 ESTOP.
REQ-020 beep_mode  out  2  beeper mode: 0 off, 1 continuous, 2 2 Hz, 3 4 Hz.

Function
REQ-021 States SHALL be SETTING=0, RUNNING=1, SWITCHING=2, DONE=3, ERROR=4, FATAL=5; codes 6 and 7 SHALL return to SETTING.
REQ-022 estop SHALL pass through a 2-flop synchronizer; pill_pulse SHALL pass through a 2-flop synchronizer followed by a rising-edge detector.
REQ-023 now_pills SHALL increment at the second clk_1khz edge after the edge where pill_pulse is first sampled high; pill edges outside RUNNING SHALL be ignored.
REQ-024 SETTING: start with every target digit at or below 9, target_pills nonzero and target_bottles nonzero -> RUNNING, counters cleared, hopper timer loaded; otherwise start SHALL be ignored.
REQ-025 RUNNING: hopper_en=1, conveyor_en=0; each pill SHALL BCD-increment now_pills (009->010, 099->100) and reload the hopper timer to HOPPER_SEC*TICKS_PER_SEC.
REQ-026 RUNNING, registered now_pills==target_pills: next edge, now_bottles+1; -> DONE if the new value equals target_bottles, else -> SWITCHING with the switch timer loaded to SWITCH_SEC*TICKS_PER_SEC.
REQ-027 RUNNING, hopper timer reaches 0 -> ERROR, err_code=1.
REQ-028 SWITCHING: hopper_en=0, conveyor_en=1; at timer expiry, conveyor_ok=1 -> RUNNING (now_pills cleared, hopper timer reloaded); conveyor_ok=0 -> ERROR, err_code=2.
REQ-029 ERROR: both enables 0, counters held; clr_err SHALL return to the faulted state with that state's timer reloaded, err_code=0.
REQ-030 DONE: both enables 0, counts held for display; start -> SETTING with counters cleared.
REQ-031 Synchronized estop=1 in any state -> FATAL, err_code=3, enables 0; FATAL SHALL exit only via switch_clr.
REQ-032 Priority SHALL be estop > pill edge > timer expiry > start/clr_err; a pill edge coinciding with hopper expiry SHALL count and reload.
REQ-033 Target inputs SHALL be sampled on start and held internally; later changes SHALL have no effect until the next SETTING.
REQ-034 beep_mode SHALL be 1 in FATAL, 2 in ERROR, 3 in DONE, and 0 otherwise.

Reset
REQ-035 switch_clr=1 SHALL immediately force state=SETTING, counters=0, timers=0, enables=0, err_code=0, beep_mode=0, and synchronizers=0, including mid-RUNNING.

Structure
REQ-036 State codes, err_code values and beep_mode values SHALL live in the shared package fill_pkg.
REQ-037 One sub-module, tick_timer (loadable down-counter with an expiry flag), SHALL be instanced twice: hopper and switch.

Verification (TICKS_PER_SEC=10, SWITCH_SEC=2, HOPPER_SEC=3)
REQ-038 Targets 003/02, start, 6 pills at 5-cycle spacing -> SWITCHING 20 cycles between bottles, then DONE, now_bottles=02, beep_mode=3.
REQ-039 Targets 012/01, 12 pills -> now_pills shows 009->010->011->012, then DONE.
REQ-040 RUNNING with no pill for 30 cycles -> ERROR, err_code=1, hopper_en=0; clr_err -> RUNNING with now_pills unchanged.
REQ-041 conveyor_ok=0 at SWITCHING expiry -> ERROR, err_code=2; set conveyor_ok=1, clr_err -> SWITCHING for 20 cycles -> RUNNING.
REQ-042 estop in RUNNING -> FATAL within 3 cycles, beep_mode=1; start and clr_err ignored; switch_clr -> SETTING, all outputs 0.
REQ-043 Start with target_pills=000 or digit 0xA -> remains in SETTING.
